// File: rtl/score_accumulator_if.sv
// Handshake bundle between the FPMac partial stream, the score accumulator and the score consumer.
// The slave modport is the accumulator's view; the master modport drives partials and accepts scores.
interface score_accumulator_if #(
  parameter int DATA_WIDTH = 16,
  parameter int CNT_WIDTH  = 3
);
  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  out_sat;
  logic [CNT_WIDTH-1:0]  chunk_cnt;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_sat,
    output chunk_cnt
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_sat,
    input  chunk_cnt
  );
endinterface

// File: rtl/score_accumulator.sv
// Sums NUM_CHUNKS Q8.8 partial dot products, scales by a right shift and saturates to one score per row.
// Define SCORE_ACC_ROUND_EN to round half-up before the shift instead of truncating.
module score_accumulator #(
  parameter int DATA_WIDTH  = 16,
  parameter int FRAC_BITS   = 8,
  parameter int NUM_CHUNKS  = 4,
  parameter int ACC_WIDTH   = 24,
  parameter int SCALE_SHIFT = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  score_accumulator_if.slave   bus
);
  localparam int CNT_W = $clog2(NUM_CHUNKS + 1);

  if (NUM_CHUNKS < 1 || FRAC_BITS > DATA_WIDTH ||
      ACC_WIDTH < DATA_WIDTH + $clog2(NUM_CHUNKS) + 1 ||
      SCALE_SHIFT < 0 || SCALE_SHIFT > ACC_WIDTH - 1) begin : g_bad_cfg
    $error("score_accumulator: illegal parameter combination");
  end

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e                state_q;
  logic [ACC_WIDTH-1:0]  acc_q;
  logic [CNT_W-1:0]      cnt_q;
  logic                  in_ready_q;
  logic                  out_valid_q;
  logic [DATA_WIDTH-1:0] out_data_q;
  logic                  out_sat_q;

  logic                  accept;
  logic                  last;
  logic [ACC_WIDTH-1:0]  sum_d;
  logic [ACC_WIDTH-1:0]  rounded_d;
  logic [ACC_WIDTH-1:0]  scaled_d;
  logic                  sat_d;
  logic [DATA_WIDTH-1:0] score_d;

`ifdef SCORE_ACC_ROUND_EN
  localparam logic [ACC_WIDTH-1:0] ROUND_INC = (SCALE_SHIFT > 0) ?
    (ACC_WIDTH'(1) << ((SCALE_SHIFT > 0) ? SCALE_SHIFT - 1 : 0)) : '0;
`endif

  // in_ready_q is only ever high in ACCUM, so it alone qualifies an accept.
  always_comb begin
    accept   = bus.in_valid & in_ready_q;
    last     = (cnt_q == CNT_W'(NUM_CHUNKS - 1));
    sum_d    = acc_q + ACC_WIDTH'(bus.in_data);
`ifdef SCORE_ACC_ROUND_EN
    rounded_d = sum_d + ROUND_INC;
`else
    rounded_d = sum_d;
`endif
    scaled_d = rounded_d >> SCALE_SHIFT;
    sat_d    = |scaled_d[ACC_WIDTH-1:DATA_WIDTH];
    score_d  = sat_d ? {DATA_WIDTH{1'b1}} : scaled_d[DATA_WIDTH-1:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACCUM;
      acc_q       <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      case (state_q)
        ACCUM: begin
          in_ready_q <= 1'b1;
          if (accept) begin
            acc_q <= sum_d;
            cnt_q <= cnt_q + CNT_W'(1);
            if (last) begin
              out_data_q  <= score_d;
              out_sat_q   <= sat_d;
              out_valid_q <= 1'b1;
              in_ready_q  <= 1'b0;
              state_q     <= HOLD;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= ACCUM;
          end
        end
        default: state_q <= ACCUM;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sat   = out_sat_q;
  assign bus.chunk_cnt = cnt_q;
endmodule

// File: tb/tb_score_accumulator.sv
// Directed bench for score_accumulator: instance a uses default parameters, instance b uses SCALE_SHIFT = 0.
// Inputs change and outputs are sampled on the falling clock edge.
module tb_score_accumulator;
  logic clk;
  logic rst_n;
  int   testsRun;
  int   testsFailed;

  score_accumulator_if #(.DATA_WIDTH(16), .CNT_WIDTH(3)) a ();
  score_accumulator_if #(.DATA_WIDTH(16), .CNT_WIDTH(3)) b ();

  score_accumulator dutA (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a.slave)
  );

  score_accumulator #(.SCALE_SHIFT(0)) dutB (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  // Called at a falling edge; returns at the falling edge after the partial was accepted.
  task automatic applyStimulus(input bit useB, input logic [15:0] d);
    int n;
    n = 0;
    if (useB) begin
      b.in_valid = 1'b1;
      b.in_data  = d;
    end else begin
      a.in_valid = 1'b1;
      a.in_data  = d;
    end
    while (!(useB ? b.in_ready : a.in_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("pushReady", {31'd0, (useB ? b.in_ready : a.in_ready)}, 32'd1);
    @(negedge clk);
    if (useB) b.in_valid = 1'b0;
    else      a.in_valid = 1'b0;
  endtask

  task automatic idle(input int cycles);
    for (int i = 0; i < cycles; i++) @(negedge clk);
  endtask

  logic [15:0] rowVec [12];
  logic [15:0] rowExp [3];
  int          rowsSeen;
  int          lastValidCycle;
  int          idx;
  logic [15:0] roundExp;

  initial begin
    testsRun    = 0;
    testsFailed = 0;
    rst_n       = 1'b0;
    a.in_valid  = 1'b0;
    a.in_data   = '0;
    a.out_ready = 1'b1;
    b.in_valid  = 1'b0;
    b.in_data   = '0;
    b.out_ready = 1'b1;

    // Reset state
    #3;
    checkOutput("rstInReady",  {31'd0, a.in_ready},  32'd0);
    checkOutput("rstOutValid", {31'd0, a.out_valid}, 32'd0);
    checkOutput("rstOutData",  {16'd0, a.out_data},  32'd0);
    checkOutput("rstOutSat",   {31'd0, a.out_sat},   32'd0);
    checkOutput("rstChunkCnt", {29'd0, a.chunk_cnt}, 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("postRstInReady", {31'd0, a.in_ready}, 32'd1);

    // Basic: 4 x 1.0 scaled by 1/4 over 4 chunks -> 1.0
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0100);
    checkOutput("basicValid", {31'd0, a.out_valid}, 32'd1);
    checkOutput("basicData",  {16'd0, a.out_data},  32'h0100);
    checkOutput("basicSat",   {31'd0, a.out_sat},   32'd0);
    checkOutput("basicCnt",   {29'd0, a.chunk_cnt}, 32'd4);
    checkOutput("basicHoldReady", {31'd0, a.in_ready}, 32'd0);
    @(negedge clk);
    checkOutput("basicValidDrop", {31'd0, a.out_valid}, 32'd0);
    checkOutput("basicCntClear",  {29'd0, a.chunk_cnt}, 32'd0);
    checkOutput("basicReadyBack", {31'd0, a.in_ready},  32'd1);

    // Bubbles and backpressure: 0x200+0x80+0+0x180 = 0x400 -> 0x100
    a.out_ready = 1'b0;
    applyStimulus(1'b0, 16'h0200);
    idle(1);
    applyStimulus(1'b0, 16'h0080);
    idle(3);
    checkOutput("bubbleCnt", {29'd0, a.chunk_cnt}, 32'd2);
    applyStimulus(1'b0, 16'h0000);
    idle(2);
    applyStimulus(1'b0, 16'h0180);
    checkOutput("bubbleValid", {31'd0, a.out_valid}, 32'd1);
    checkOutput("bubbleData",  {16'd0, a.out_data},  32'h0100);
    a.in_valid = 1'b1;
    a.in_data  = 16'hFFFF;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("holdData",    {16'd0, a.out_data},  32'h0100);
      checkOutput("holdInReady", {31'd0, a.in_ready},  32'd0);
      checkOutput("holdValid",   {31'd0, a.out_valid}, 32'd1);
      checkOutput("holdCnt",     {29'd0, a.chunk_cnt}, 32'd4);
    end
    a.in_valid  = 1'b0;
    a.out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bpRelease", {31'd0, a.out_valid}, 32'd0);
    checkOutput("bpCntClear", {29'd0, a.chunk_cnt}, 32'd0);

    // Rounding: 3 >> 2 truncates to 0, rounds half-up to 1
`ifdef SCORE_ACC_ROUND_EN
    roundExp = 16'h0001;
`else
    roundExp = 16'h0000;
`endif
    applyStimulus(1'b0, 16'h0003);
    for (int i = 0; i < 3; i++) applyStimulus(1'b0, 16'h0000);
    checkOutput("roundValid", {31'd0, a.out_valid}, 32'd1);
    checkOutput("roundData",  {16'd0, a.out_data},  {16'd0, roundExp});
    checkOutput("roundSat",   {31'd0, a.out_sat},   32'd0);
    @(negedge clk);

    // Saturation on the unshifted instance: 4 x 0x8000 = 0x20000
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h8000);
    checkOutput("satValid", {31'd0, b.out_valid}, 32'd1);
    checkOutput("satData",  {16'd0, b.out_data},  32'hFFFF);
    checkOutput("satFlag",  {31'd0, b.out_sat},   32'd1);
    @(negedge clk);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'h0040);
    checkOutput("unsatData", {16'd0, b.out_data}, 32'h0100);
    checkOutput("unsatFlag", {31'd0, b.out_sat},  32'd0);
    @(negedge clk);

    // Reset mid-accumulation discards the partial sum
    applyStimulus(1'b0, 16'h1000);
    applyStimulus(1'b0, 16'h1000);
    checkOutput("midCnt", {29'd0, a.chunk_cnt}, 32'd2);
    rst_n = 1'b0;
    #1;
    checkOutput("midRstValid", {31'd0, a.out_valid}, 32'd0);
    checkOutput("midRstCnt",   {29'd0, a.chunk_cnt}, 32'd0);
    checkOutput("midRstReady", {31'd0, a.in_ready},  32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("midRstReadyBack", {31'd0, a.in_ready}, 32'd1);
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 16'h0100);
    checkOutput("midRstData",  {16'd0, a.out_data},  32'h0100);
    checkOutput("midRstValid2", {31'd0, a.out_valid}, 32'd1);
    @(negedge clk);

    // Back-to-back rows with in_valid held high
    for (int i = 0; i < 4; i++) rowVec[i] = 16'h0400;
    rowVec[4] = 16'h0010; rowVec[5] = 16'h0020; rowVec[6] = 16'h0030; rowVec[7] = 16'h0040;
    for (int i = 8; i < 12; i++) rowVec[i] = 16'hFFFF;
    rowExp[0] = 16'h0400;
    rowExp[1] = 16'h0028;
    rowExp[2] = 16'hFFFF;
    rowsSeen       = 0;
    lastValidCycle = -1;
    idx            = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (a.out_valid) begin
        if (rowsSeen < 3) begin
          checkOutput("b2bData", {16'd0, a.out_data}, {16'd0, rowExp[rowsSeen]});
          checkOutput("b2bSat",  {31'd0, a.out_sat},  32'd0);
        end
        if (lastValidCycle >= 0) checkOutput("b2bSpacing", cyc - lastValidCycle, 32'd5);
        lastValidCycle = cyc;
        rowsSeen++;
      end
      if (a.in_ready) begin
        if (idx < 12) begin
          a.in_valid = 1'b1;
          a.in_data  = rowVec[idx];
          idx++;
        end else begin
          a.in_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    a.in_valid = 1'b0;
    checkOutput("b2bRows", rowsSeen, 32'd3);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
